dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the MEM-stage data memory interface.
- Accepts one load/store request at a time from the pipeline's memory stage (address, direction, transfer size, store data).
- Models a multi-cycle, byte-addressable, big-endian data memory and returns a single-cycle response pulse.
- Raises stall to freeze the pipeline while an access is outstanding; replaces the single-cycle data memory when multi-cycle timing is enabled.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, at least 8.
LATENCY, 3, cycles from request acceptance edge to resp_valid cycle; at least 1.

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  64  byte address
req_wdata  input  64  store data, right-justified
req_size  input  4  transfer size in bytes; legal values 1, 2, 4, 8
req_ready  output  1  responder can accept a request this cycle
resp_valid  output  1  one-cycle pulse: access complete
resp_rdata  output  64  load data, zero-extended; 0 for stores and errors
resp_err  output  1  qualified by resp_valid; access faulted
stall  output  1  pipeline freeze request

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE, latency counter 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, stall=0.
  - Memory array contents are not cleared.
- States:
  - IDLE: no access in flight.
  - BUSY: counting down latency.
  - RESP: resp_valid asserted for exactly this one cycle.
- Transfers:
  - Accept occurs on a rising edge where req_valid and req_ready are both 1; request fields are latched on that edge.
  - req_ready = 1 in IDLE and in RESP, 0 in BUSY. Back-to-back accept in the RESP cycle is allowed.
- Transitions:
  - IDLE or RESP with accept: go to RESP if LATENCY=1, else go to BUSY with counter = LATENCY-1.
  - BUSY: decrement counter each edge; when counter reaches 1, the next edge goes to RESP.
  - RESP without accept: go to IDLE.
  - IDLE without accept: stay in IDLE.
- Latency: accept on edge T means resp_valid is high during the cycle following edge T+LATENCY-1, i.e. LATENCY edges after T.
- Memory action: performed on the edge entering RESP. Store bytes are written; load data is registered into resp_rdata and held until the next RESP.
  - A request accepted in a RESP cycle sees any store that completed in that same RESP.
- Byte order: big-endian.
  - Store: byte at addr receives req_wdata[8*size-1 -: 8]; remaining bytes follow in descending significance.
  - Load: bytes are assembled in the same order into the low 8*size bits; upper bits are zero.
- Errors: resp_err=1, no array write, resp_rdata=0, on any of:
  - req_size not in {1,2,4,8};
  - req_addr not aligned to req_size;
  - req_addr + req_size > DEPTH_BYTES.
  - Address arithmetic uses the full 64 bits; no wrap-around.
- stall = req_valid AND not in a state able to complete the request this cycle.
  - Precisely: stall = req_valid & ~(state==RESP), covering both IDLE-accept and BUSY.
  - The pipeline holds its request stable while stall=1. A request presented in IDLE stalls until its own RESP cycle.
- req_valid dropping mid-access does not cancel the access; the latched request completes.
- Simultaneous reset and RESP: reset wins. resp_valid drops immediately and any in-flight store is not committed.

Decomposition:
- Shared package dmem_pkg:
  - typedef dmem_state_t {IDLE, BUSY, RESP};
  - localparams SIZE_B=1, SIZE_H=2, SIZE_W=4, SIZE_D=8;
  - function size_legal(size).
- One sub-module, dmem_array:
  - byte array with registered big-endian read/write;
  - ports: clk, en, we, addr, size, wdata, rdata.
- The FSM, counter, error check and stall logic stay in dmem_responder.

Test Plan:
1. Reset: hold reset_n=0 mid-BUSY -> req_ready=1, resp_valid=0, stall=0 immediately (asynchronous); the store in flight is not committed.
2. Store then load, LATENCY=3: store addr=0x80 wdata=0x45 size=8 accepted at edge T -> resp_valid high after edge T+2, resp_err=0. Load addr=0x80 size=8 accepted in that RESP cycle -> resp_rdata=0x0000000000000045 three edges later.
3. Endianness: store addr=0x10 wdata=0x1122334455667788 size=8, then load addr=0x10 size=1 -> rdata=0x11; load addr=0x14 size=4 -> rdata=0x55667788.
4. Errors:
   - addr=0x13 size=4 -> resp_err=1, rdata=0, memory unchanged;
   - size=3 -> resp_err=1;
   - addr=DEPTH_BYTES-4 size=8 -> resp_err=1.
5. Stall and handshake: req_valid held high for LATENCY=3 -> stall=1 for the accept cycle and both BUSY cycles, 0 in the RESP cycle; req_ready=0 throughout BUSY; exactly one resp_valid pulse per accept.
6. LATENCY=1 build: back-to-back loads on consecutive edges -> resp_valid high every cycle, stall=0 in every RESP cycle, data matches per address.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle MEM-stage data memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

  localparam logic [3:0] SIZE_B = 4'd1;
  localparam logic [3:0] SIZE_H = 4'd2;
  localparam logic [3:0] SIZE_W = 4'd4;
  localparam logic [3:0] SIZE_D = 4'd8;

  function automatic logic size_legal(input logic [3:0] size);
    return size inside {SIZE_B, SIZE_H, SIZE_W, SIZE_D};
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Byte-addressable big-endian storage with registered read and write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    size,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  logic [7:0]  mem [DEPTH_BYTES];
  logic [63:0] w_rd;

  // First byte lands in the most significant position of the result.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < int'(SIZE_D); i++)
      if (i < int'(size)) w_rd = {w_rd[55:0], mem[addr + AW'(i)]};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < int'(SIZE_D); i++)
          if (i < int'(size)) mem[addr + AW'(i)] <= wdata[8*(int'(size)-1-i) +: 8];
      end else begin
        rdata <= w_rd;
      end
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: accepts one request, counts latency,
// performs the access on entry to RESP and pulses resp_valid for one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  dmem_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_write, r_err, r_zero;
  logic [63:0]   r_addr, r_wdata;
  logic [3:0]    r_size;

  logic          w_accept, w_go_resp, w_err;
  logic          w_op_write;
  logic [63:0]   w_op_addr, w_op_wdata, w_arr_rdata;
  logic [3:0]    w_op_size;

  assign req_ready = (r_state != BUSY);
  assign w_accept  = req_valid & req_ready;
  assign w_go_resp = (LATENCY == 1) ? w_accept : (r_state == BUSY && r_cnt == CW'(1));

  // With single-cycle latency the access happens on the accept edge itself.
  assign w_op_write = (LATENCY == 1) ? req_write : r_write;
  assign w_op_addr  = (LATENCY == 1) ? req_addr  : r_addr;
  assign w_op_wdata = (LATENCY == 1) ? req_wdata : r_wdata;
  assign w_op_size  = (LATENCY == 1) ? req_size  : r_size;

  assign w_err = !size_legal(w_op_size)
               | (|(w_op_addr & {60'd0, w_op_size - 4'd1}))
               | (({1'b0, w_op_addr} + 65'(w_op_size)) > 65'(DEPTH_BYTES));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) w_state_nxt = RESP;
          else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CW'(LATENCY - 1);
          end
        end else if (r_state == RESP) begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = RESP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_err   <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
      end
      if (w_go_resp) begin
        r_err  <= w_err;
        r_zero <= w_err | w_op_write;
      end
    end
  end

  // reset_n gate keeps an access from landing while reset is held.
  dmem_array #(.DEPTH_BYTES(DEPTH_BYTES), .AW(AW)) u_array (
    .clk   (clk),
    .en    (w_go_resp & ~w_err & reset_n),
    .we    (w_op_write),
    .addr  (w_op_addr[AW-1:0]),
    .size  (w_op_size),
    .wdata (w_op_wdata),
    .rdata (w_arr_rdata)
  );

  assign resp_valid = (r_state == RESP);
  assign resp_err   = r_err & resp_valid;
  assign resp_rdata = r_zero ? '0 : w_arr_rdata;
  assign stall      = req_valid & (r_state != RESP);
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=3 and LATENCY=1 instances against a byte-array model.
module tb_dmem_responder;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        v3 = 0, w3 = 0, rdy3, rv3, err3, st3;
  logic [63:0] a3 = 0, d3 = 0, rdat3;
  logic [3:0]  s3 = 0;
  logic        v1 = 0, w1 = 0, rdy1, rv1, err1, st1;
  logic [63:0] a1 = 0, d1 = 0, rdat1;
  logic [3:0]  s1 = 0;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(3)) u3 (
    .clk(clk), .reset_n(reset_n), .req_valid(v3), .req_write(w3), .req_addr(a3),
    .req_wdata(d3), .req_size(s3), .req_ready(rdy3), .resp_valid(rv3),
    .resp_rdata(rdat3), .resp_err(err3), .stall(st3));

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_write(w1), .req_addr(a1),
    .req_wdata(d1), .req_size(s1), .req_ready(rdy1), .resp_valid(rv1),
    .resp_rdata(rdat1), .resp_err(err1), .stall(st1));

  int total = 0, bad = 0;
  logic [7:0] mdl [2][DEPTH];

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [3:0]  s;
    logic        e;
    logic [63:0] r;
  } vec_t;
  localparam int NT = 16;
  vec_t tbl [NT];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference: legality from size/alignment/bounds, then big-endian byte copy.
  function automatic void model(input int k, input logic w, input logic [63:0] a, d,
                                input logic [3:0] s, output logic e, output logic [63:0] r);
    int n, idx;
    n = int'(s);
    r = '0;
    if (!(n == 1 || n == 2 || n == 4 || n == 8)) e = 1'b1;
    else if ((a % 64'(n)) != 0) e = 1'b1;
    else if (({1'b0, a} + 65'(n)) > 65'(DEPTH)) e = 1'b1;
    else e = 1'b0;
    if (!e)
      for (int i = 0; i < n; i++) begin
        idx = int'(a[31:0]) + i;
        if (w) mdl[k][idx] = 8'(d >> (8 * (n - 1 - i)));
        else   r = (r << 8) | 64'(mdl[k][idx]);
      end
  endfunction

  task automatic xact3(input logic w, input logic [63:0] a, d, input logic [3:0] s,
                       output logic e, output logic [63:0] r, output int edges,
                       output int hs, output logic st0);
    v3 = 1; w3 = w; a3 = a; d3 = d; s3 = s;
    #1 st0 = st3;
    edges = 0; hs = 0;
    do begin
      @(posedge clk); #1; edges++;
      if (!rv3 && (rdy3 || !st3)) hs++;
    end while (!rv3 && edges < 20);
    if (rv3 && (st3 || !rdy3)) hs++;
    e = err3; r = rdat3;
  endtask

  task automatic run3(input string nm, input logic w, input logic [63:0] a, d,
                      input logic [3:0] s, output logic e, output logic [63:0] r,
                      output logic me, output logic [63:0] mr, output logic st0);
    int ed, hs;
    model(0, w, a, d, s, me, mr);
    xact3(w, a, d, s, e, r, ed, hs, st0);
    chk({nm, ".lat"}, 64'(ed), 64'd3);
    chk({nm, ".hs"}, 64'(hs), 64'd0);
  endtask

  initial begin
    logic        e, me, st0, ok, w;
    logic [63:0] r, mr, a, d;
    logic [3:0]  s;
    logic [3:0]  sizes [4];
    int          pick;
    sizes[0] = 4'd1; sizes[1] = 4'd2; sizes[2] = 4'd4; sizes[3] = 4'd8;

    tbl[0]  = '{1'b1, 64'h80, 64'h45, 4'd8, 1'b0, 64'h0};
    tbl[1]  = '{1'b0, 64'h80, 64'h0, 4'd8, 1'b0, 64'h45};
    tbl[2]  = '{1'b1, 64'h10, 64'h1122334455667788, 4'd8, 1'b0, 64'h0};
    tbl[3]  = '{1'b0, 64'h10, 64'h0, 4'd1, 1'b0, 64'h11};
    tbl[4]  = '{1'b0, 64'h14, 64'h0, 4'd4, 1'b0, 64'h55667788};
    tbl[5]  = '{1'b0, 64'h12, 64'h0, 4'd2, 1'b0, 64'h3344};
    tbl[6]  = '{1'b1, 64'h13, 64'hDEADBEEF, 4'd4, 1'b1, 64'h0};
    tbl[7]  = '{1'b0, 64'h10, 64'h0, 4'd8, 1'b0, 64'h1122334455667788};
    tbl[8]  = '{1'b0, 64'h10, 64'h0, 4'd3, 1'b1, 64'h0};
    tbl[9]  = '{1'b1, 64'(DEPTH - 4), 64'h99, 4'd8, 1'b1, 64'h0};
    tbl[10] = '{1'b1, 64'(DEPTH - 8), 64'hA1A2A3A4B1B2B3B4, 4'd8, 1'b0, 64'h0};
    tbl[11] = '{1'b0, 64'(DEPTH - 4), 64'h0, 4'd4, 1'b0, 64'hB1B2B3B4};
    tbl[12] = '{1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 4'd8, 1'b1, 64'h0};
    tbl[13] = '{1'b1, 64'h20, 64'hFFFFABCD, 4'd2, 1'b0, 64'h0};
    tbl[14] = '{1'b0, 64'h21, 64'h0, 4'd1, 1'b0, 64'hCD};
    tbl[15] = '{1'b0, 64'h20, 64'h0, 4'd2, 1'b0, 64'hABCD};

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 64'(rdy3), 64'd1);
    chk("rst.valid", 64'(rv3), 64'd0);
    chk("rst.rdata", rdat3, 64'd0);
    chk("rst.err", 64'(err3), 64'd0);
    chk("rst.stall", 64'(st3), 64'd0);
    chk("rst1.valid", 64'(rv1), 64'd0);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++) begin
      run3($sformatf("pre%0d", i), 1'b1, 64'(i * 8), {$urandom, $urandom}, 4'd8, e, r, me, mr, st0);
      chk($sformatf("pre%0d.err", i), 64'(e), 64'd0);
    end

    for (int i = 0; i < NT; i++) begin
      run3($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, e, r, me, mr, st0);
      if (i == 0) chk("stall.resp_cycle", 64'(st0), 64'd0);
      chk($sformatf("tbl%0d.err", i), 64'(e), 64'(tbl[i].e));
      chk($sformatf("tbl%0d.rdata", i), r, tbl[i].r);
    end

    // Reset while a store sits one edge away from committing.
    v3 = 1; w3 = 1; a3 = 64'h40; d3 = 64'h0BADF00D0BADF00D; s3 = 4'd8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    v3 = 0; reset_n = 0;
    #1;
    chk("arst.ready", 64'(rdy3), 64'd1);
    chk("arst.valid", 64'(rv3), 64'd0);
    chk("arst.stall", 64'(st3), 64'd0);
    chk("arst.err", 64'(err3), 64'd0);
    chk("arst.rdata", rdat3, 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("arst.hold_valid", 64'(rv3), 64'd0);
    @(negedge clk) reset_n = 1;
    run3("arst.load", 1'b0, 64'h40, 64'h0, 4'd8, e, r, me, mr, st0);
    chk("stall.accept_cycle", 64'(st0), 64'd1);
    chk("arst.load.err", 64'(e), 64'(me));
    chk("arst.load.rdata", r, mr);

    for (int i = 0; i < 200; i++) begin
      pick = int'($urandom_range(0, 9));
      w = 1'($urandom);
      d = {$urandom, $urandom};
      s = sizes[$urandom_range(0, 3)];
      a = 64'($urandom_range(0, 255));
      if (pick == 0) s = 4'($urandom_range(0, 15));
      else if (pick == 2) a = 64'(DEPTH - int'($urandom_range(1, 8)));
      else if (pick == 3) a = 64'hFFFFFFFFFFFFFFF8 | 64'($urandom_range(0, 7));
      else if (pick != 1) a = a & ~64'(s - 4'd1);
      run3($sformatf("rnd%0d", i), w, a, d, s, e, r, me, mr, st0);
      chk($sformatf("rnd%0d.err", i), 64'(e), 64'(me));
      chk($sformatf("rnd%0d.rdata", i), r, mr);
      if ($urandom_range(0, 2) == 0) begin
        v3 = 0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          chk($sformatf("rnd%0d.single_pulse", i), 64'(rv3), 64'd0);
        end
      end
    end
    v3 = 0;

    // Single-cycle build: every request completes on its own accept edge.
    for (int i = 0; i < 56; i++) begin
      w = (i < 16);
      s = (i < 16) ? 4'd8 : sizes[$urandom_range(0, 3)];
      a = (i < 16) ? 64'(i * 8) : (64'($urandom_range(0, 127)) & ~64'(s - 4'd1));
      d = {$urandom, $urandom};
      model(1, w, a, d, s, me, mr);
      v1 = 1; w1 = w; a1 = a; d1 = d; s1 = s;
      @(posedge clk); #1;
      ok = rv1 & ~st1 & rdy1;
      chk($sformatf("l1_%0d.hs", i), 64'(ok), 64'd1);
      chk($sformatf("l1_%0d.err", i), 64'(err1), 64'(me));
      chk($sformatf("l1_%0d.rdata", i), rdat1, mr);
    end
    v1 = 0;
    @(posedge clk); #1;
    chk("l1.idle_valid", 64'(rv1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
